// File: rtl/uart_io_peripheral.sv
// Memory-mapped 8N1 UART slave: buffered transmitter with a TX FIFO, a receiver that
// holds one byte and reports error flags, and a programmable baud divisor.
module uart_io_peripheral #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    // Divisors below 4 would leave no room for the half-bit RX sample point.
    function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] val);
        return (val < MIN_DIV) ? MIN_DIV : val;
    endfunction

    logic acc_wr, acc_rd;
    logic wr_tx, wr_stat, wr_div, rx_pop;

    assign acc_wr  = sel & we;
    assign acc_rd  = sel & re;
    assign wr_tx   = acc_wr && (addr[3:2] == REG_TXDATA);
    assign wr_stat = acc_wr && (addr[3:2] == REG_STATUS);
    assign wr_div  = acc_wr && (addr[3:2] == REG_BAUDDIV);
    assign rx_pop  = acc_rd && (addr[3:2] == REG_RXDATA);

    logic unused_bits;
    assign unused_bits = ^{addr[7:4], addr[1:0], wdata[31:8]};

    logic [DIV_W-1:0] baud_div, div_m1, div_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div <= DIV_W'(DEFAULT_DIV);
        end else if (wr_div) begin
            baud_div <= sat_div(wdata[DIV_W-1:0]);
        end
    end

    assign div_m1   = baud_div - DIV_W'(1);
    assign div_half = baud_div >> 1;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          tx_full, tx_empty, fifo_push, fifo_pop, tx_drop_set;
    logic [7:0]    fifo_head;

    assign tx_full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign tx_empty    = (fifo_cnt == '0);
    // A full FIFO still accepts a byte when the transmitter drains one on the same edge.
    assign fifo_push   = wr_tx && (!tx_full || fifo_pop);
    assign tx_drop_set = wr_tx && !fifo_push;
    assign fifo_head   = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= wdata[7:0];
    end

    uart_state_t      tx_state, tx_state_nx;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]       tx_idx, tx_idx_nx;
    logic [7:0]       tx_shift, tx_shift_nx;
    logic             tx_line_nx, tx_tick, tx_busy;

    assign tx_tick = (tx_cnt == '0);
    assign tx_busy = (tx_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_idx   <= tx_idx_nx;
            uart_tx  <= tx_line_nx;
        end
    end

    always_ff @(posedge clk) begin
        tx_shift <= tx_shift_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_idx_nx   = tx_idx;
        tx_shift_nx = tx_shift;
        tx_line_nx  = 1'b1;
        fifo_pop    = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    fifo_pop    = 1'b1;
                    tx_shift_nx = fifo_head;
                    tx_cnt_nx   = div_m1;
                    tx_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    tx_idx_nx   = '0;
                    tx_cnt_nx   = div_m1;
                    tx_state_nx = ST_DATA;
                end else begin
                    tx_cnt_nx = tx_cnt - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    tx_cnt_nx = div_m1;
                    if (tx_idx == 3'd7) begin
                        tx_state_nx = ST_STOP;
                    end else begin
                        tx_idx_nx = tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_tick) begin
                    // Chain straight into the next start bit so queued frames are gapless.
                    if (!tx_empty) begin
                        fifo_pop    = 1'b1;
                        tx_shift_nx = fifo_head;
                        tx_cnt_nx   = div_m1;
                        tx_state_nx = ST_START;
                    end else begin
                        tx_state_nx = ST_IDLE;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt - DIV_W'(1);
                end
            end
            default: tx_state_nx = ST_IDLE;
        endcase
        case (tx_state_nx)
            ST_START: tx_line_nx = 1'b0;
            ST_DATA:  tx_line_nx = tx_shift_nx[tx_idx_nx];
            default:  tx_line_nx = 1'b1;
        endcase
    end

    logic rx_s1, rx_s2, rx_s3, rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 & ~rx_s2;

    uart_state_t      rx_state, rx_state_nx;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]       rx_idx, rx_idx_nx;
    logic [7:0]       rx_shift, rx_shift_nx;
    logic             rx_tick, rx_done;

    assign rx_tick = (rx_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_idx   <= rx_idx_nx;
        end
    end

    always_ff @(posedge clk) begin
        rx_shift <= rx_shift_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_idx_nx   = rx_idx;
        rx_shift_nx = rx_shift;
        rx_done     = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_nx   = div_half;
                    rx_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    // Line back high at mid start bit: treat it as a glitch.
                    if (rx_s2) begin
                        rx_state_nx = ST_IDLE;
                    end else begin
                        rx_idx_nx   = '0;
                        rx_cnt_nx   = div_m1;
                        rx_state_nx = ST_DATA;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    rx_shift_nx[rx_idx] = rx_s2;
                    rx_cnt_nx           = div_m1;
                    if (rx_idx == 3'd7) begin
                        rx_state_nx = ST_STOP;
                    end else begin
                        rx_idx_nx = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (rx_tick) begin
                    rx_done     = 1'b1;
                    rx_state_nx = ST_IDLE;
                end else begin
                    rx_cnt_nx = rx_cnt - DIV_W'(1);
                end
            end
            default: rx_state_nx = ST_IDLE;
        endcase
    end

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ovr, rx_ferr, tx_drop;
    logic       rx_load, ovr_set, ferr_set;
    logic [2:0] w1c;

    assign rx_load  = rx_done && (!rx_valid || rx_pop);
    assign ovr_set  = rx_done && rx_valid && !rx_pop;
    assign ferr_set = rx_done && !rx_s2;
    assign w1c      = wr_stat ? wdata[6:4] : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_ferr  <= 1'b0;
            tx_drop  <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_valid <= 1'b1;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
            // A set on the same edge as a clear leaves the flag set.
            tx_drop <= tx_drop_set | (tx_drop & ~w1c[2]);
            rx_ferr <= ferr_set    | (rx_ferr & ~w1c[1]);
            rx_ovr  <= ovr_set     | (rx_ovr  & ~w1c[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_load) rx_byte <= rx_shift;
    end

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (addr[3:2])
            REG_RXDATA:  rd_mux = {24'b0, rx_byte};
            REG_STATUS:  rd_mux = {25'b0, tx_drop, rx_ferr, rx_ovr, rx_valid,
                                   tx_busy, tx_empty, tx_full};
            REG_BAUDDIV: rd_mux = 32'(baud_div);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (acc_rd) begin
            rdata <= rd_mux;
        end
    end

endmodule

// File: doc/uart_io_peripheral.md
Name: uart_io_peripheral

Overview:
- Memory-mapped UART slave on the I/O bus, directly downstream of the I/O bus decoder.
- Claims the UART window 0xFFFFFDxx. `sel` is driven by decoder write-select bit 2; `rdata` feeds read-mux input 2'b10.
- Provides a buffered 8N1 transmitter (TX FIFO), a single-byte-buffered receiver with error flags, and a programmable baud divisor.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor register.
- DEFAULT_DIV, 868, reset value of the baud divisor (100 MHz / 115200).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- sel  input  1  peripheral select (decoder write-select bit 2).
- we  input  1  store strobe; qualified by sel.
- re  input  1  load strobe; qualified by sel.
- addr  input  8  byte offset (address[7:0]); only bits [3:2] are decoded.
- wdata  input  32  store data.
- rdata  output  32  registered load data.
- uart_tx  output  1  serial out; idles high.
- uart_rx  input  1  asynchronous serial in.

Behaviour:
- Register map (word offsets):
  - 0x0 TXDATA: W pushes wdata[7:0]; R returns 0.
  - 0x4 RXDATA: R returns {24'b0, rx_byte} and clears rx_valid (pop); W ignored.
  - 0x8 STATUS: R returns {25'b0, tx_drop, rx_ferr, rx_ovr, rx_valid, tx_busy, tx_empty, tx_full}, bits [6:0]. W is write-1-to-clear for bits [6:4]; other bits are ignored.
  - 0xC BAUDDIV: R/W, zero-extended. A written value below 4 is stored as 4.
- Access rules:
  - An access occurs only when sel=1. If we and re are both 1, the write takes effect and the read also returns data.
  - rdata is registered: it is valid the cycle after an access with sel&re and holds its value until the next read.
  - The read pop and the W1C clear take effect on the access edge.
- Reset values: rdata=0, uart_tx=1, FIFO empty, BAUDDIV=DEFAULT_DIV, all flags 0, both engines IDLE.
- TX FIFO:
  - Push when sel&we&TXDATA and (not full, or a pop occurs in the same cycle). Otherwise the byte is dropped and tx_drop is set.
  - The count wraps on pointers modulo FIFO_DEPTH.
  - tx_full = (count == FIFO_DEPTH); tx_empty = (count == 0).
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if the FIFO is not empty, pop into the shifter and go to START.
  - Each state lasts exactly BAUDDIV clocks. The divisor is sampled at each bit start.
  - DATA sends 8 bits, LSB first, using a 3-bit index. After STOP, go directly to START if the FIFO is non-empty, giving back-to-back frames with no idle gap.
  - uart_tx is registered: 0 in START, the data bit in DATA, 1 in STOP and IDLE.
  - tx_busy = 1 whenever the state is not IDLE.
- RX input: uart_rx passes through a 2-flop synchronizer. The falling-edge detect uses the synchronized signal.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: on a falling edge, go to START with the counter at BAUDDIV/2 (floor).
  - START: at the mid-bit sample, if the line is high (false start) return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits at BAUDDIV intervals, LSB first.
  - STOP: sample at mid-bit and return to IDLE on that cycle.
- Byte completion, at the stop-bit sample:
  - If the stop bit is 0, set rx_ferr; the byte is still delivered.
  - If rx_valid=1 and no pop occurs in the same cycle: keep the old byte, discard the new one, set rx_ovr.
  - Otherwise load rx_byte and set rx_valid=1. A same-cycle pop followed by a load leaves rx_valid=1 with no overrun.
- Sticky flags: if a W1C clear and a set happen in the same cycle, the set wins.
- Reset mid-frame: both FSMs return to IDLE, uart_tx goes high on the next cycle, and the FIFO contents are lost.
- Divisor arithmetic: counters are DIV_W bits and count down from a loaded value of DIV-1 to 0; the bit advances at 0.

Test Plan:
- Reset, then read STATUS → rdata=0x02 on the next cycle; read BAUDDIV → 868; uart_tx=1.
- BAUDDIV=16, write TXDATA 0xA5 → uart_tx low for 16 clocks, then bits 1,0,1,0,0,1,0,1 each 16 clocks, then high 16 clocks; tx_busy is 1 throughout, and the frame totals 160 clocks.
- BAUDDIV=4, FIFO_DEPTH=16, write 17 bytes back-to-back while the shifter holds byte 0 → all 17 accepted (16 in the FIFO plus 1 in the shifter). An 18th write sets tx_drop and tx_full=1. Frames are gapless; W1C 0x40 clears tx_drop.
- BAUDDIV=8, drive an RX frame 0x3C with stop=1 → rx_valid=1; read RXDATA → 0x3C and rx_valid=0. A 2-clock low glitch on uart_rx leaves rx_valid=0.
- Send two RX frames without reading → rx_ovr=1 and RXDATA returns the first byte. A frame with stop=0 sets rx_ferr and delivers the byte.
- Read RXDATA on the exact cycle a second byte completes → the first byte is returned, rx_valid stays 1, rx_ovr stays 0. Also: write BAUDDIV=1 and read it back → 4.
